// File: rtl/rr_select_arbiter_8_pkg.sv
// Shared constants and helper functions for the eight-way round-robin select arbiter.
// Holds the requester count, the index width, and the grant-computation helpers.
package rr_select_arbiter_8_pkg;

    localparam int NUM_REQ = 8;
    localparam int SRC_W   = 3;

    // Converts a one-hot vector to its binary index. An all-zero input gives 0.
    function automatic logic [SRC_W-1:0] onehot_to_bin(input logic [NUM_REQ-1:0] oh);
        logic [SRC_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = idx | SRC_W'(i);
        end
        return idx;
    endfunction

    // Scans upward from ptr, wrapping 7->0. The first set request wins.
    // Passing ptr=0 turns this into a lowest-index (fixed priority) pick.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic [SRC_W-1:0]   ptr);
        logic [NUM_REQ-1:0] grant;
        logic               found;
        logic [SRC_W-1:0]   idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + SRC_W'(k);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_select_arbiter_8_onehot_mux_8.sv
// Purely combinational 8:1 data selector driven by a one-hot select.
// An all-zero select produces an all-zero output.
module onehot_mux_8
    import rr_select_arbiter_8_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] d0,
    input  logic [DATA_WIDTH-1:0] d1,
    input  logic [DATA_WIDTH-1:0] d2,
    input  logic [DATA_WIDTH-1:0] d3,
    input  logic [DATA_WIDTH-1:0] d4,
    input  logic [DATA_WIDTH-1:0] d5,
    input  logic [DATA_WIDTH-1:0] d6,
    input  logic [DATA_WIDTH-1:0] d7,
    input  logic [NUM_REQ-1:0]    sel,
    output logic [DATA_WIDTH-1:0] y
);

    logic [DATA_WIDTH-1:0] d_arr [NUM_REQ];

    assign d_arr = '{d0, d1, d2, d3, d4, d5, d6, d7};

    // NOTE: y is given a default before the loop so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel[i]) y = y | d_arr[i];
        end
    end

endmodule

// File: rtl/rr_select_arbiter_8.sv
// Round-robin / fixed-priority arbiter sharing one 8:1 one-hot selector among eight requesters.
// Feeds a one-entry output register with a valid/ready handshake.
module rr_select_arbiter_8
    import rr_select_arbiter_8_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [DATA_WIDTH-1:0] d0,
    input  logic [DATA_WIDTH-1:0] d1,
    input  logic [DATA_WIDTH-1:0] d2,
    input  logic [DATA_WIDTH-1:0] d3,
    input  logic [DATA_WIDTH-1:0] d4,
    input  logic [DATA_WIDTH-1:0] d5,
    input  logic [DATA_WIDTH-1:0] d6,
    input  logic [DATA_WIDTH-1:0] d7,
    input  logic                  prio_mode,
    output logic [NUM_REQ-1:0]    ack,
    output logic [NUM_REQ-1:0]    sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [SRC_W-1:0]      out_src
);

    logic [SRC_W-1:0]      ptr_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [SRC_W-1:0]      out_src_q;
    logic [NUM_REQ-1:0]    sel_q;

    logic [NUM_REQ-1:0]    grant;
    logic [SRC_W-1:0]      winner;
    logic [DATA_WIDTH-1:0] mux_y;
    logic                  load;

    // Fixed mode starts the scan at 0 so it degenerates to lowest-index wins.
    assign grant  = rr_pick(req, prio_mode ? '0 : ptr_q);
    assign winner = onehot_to_bin(grant);
    assign load   = (|req) && (!out_valid_q || out_ready);
    assign ack    = (load && rst_n) ? grant : '0;

    onehot_mux_8 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .d4  (d4),
        .d5  (d5),
        .d6  (d6),
        .d7  (d7),
        .sel (grant),
        .y   (mux_y)
    );

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            sel_q       <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_y;
            out_src_q   <= winner;
            sel_q       <= grant;
            if (!prio_mode) ptr_q <= winner + SRC_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_rr_select_arbiter_8.sv
// Directed-vector bench for rr_select_arbiter_8 with hand-computed expected values.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_rr_select_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] d [8];
    logic       prio_mode;
    logic [7:0] ack;
    logic [7:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_src;

    int n_vec;
    int n_err;

    rr_select_arbiter_8 #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d0        (d[0]),
        .d1        (d[1]),
        .d2        (d[2]),
        .d3        (d[3]),
        .d4        (d[4]),
        .d5        (d[5]),
        .d6        (d[6]),
        .d7        (d[7]),
        .prio_mode (prio_mode),
        .ack       (ack),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req       = 8'h00;
        prio_mode = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) d[i] = 8'(i);

        // Reset hold
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("rst_valid", 32'(out_valid), 32'h0);
            check("rst_data",  32'(out_data),  32'h0);
            check("rst_sel",   32'(sel),       32'h0);
            check("rst_ack",   32'(ack),       32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin walk over two full laps
        req       = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            check("rr_ack", 32'(ack), 32'(8'h01 << (k % 8)));
            if (k > 0) begin
                check("rr_data",  32'(out_data), 32'((k - 1) % 8));
                check("rr_src",   32'(out_src),  32'((k - 1) % 8));
                check("rr_valid", 32'(out_valid), 32'h1);
            end
            @(negedge clk);
        end
        req = 8'h00;
        #1;
        check("walk_last_data", 32'(out_data), 32'h7);
        check("idle_ack",       32'(ack),      32'h0);
        @(negedge clk); #1;
        check("drain_valid", 32'(out_valid), 32'h0);
        check("drain_hold",  32'(out_data),  32'h7);
        check("drain_sel",   32'(sel),       32'h80);

        // Backpressure with req=81, ptr=0
        req       = 8'h81;
        out_ready = 1'b0;
        #1;
        check("bp_ack_first", 32'(ack), 32'h01);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'h1);
            check("bp_data",  32'(out_data),  32'h0);
            check("bp_ack",   32'(ack),       32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ack", 32'(ack), 32'h80);
        @(negedge clk);
        req = 8'h00;
        #1;
        check("bp_next_data",  32'(out_data),  32'h7);
        check("bp_next_src",   32'(out_src),   32'h7);
        check("bp_next_valid", 32'(out_valid), 32'h1);

        // Move ptr to 4, then fixed priority, then back to round-robin
        req = 8'h08;
        #1;
        check("setptr_ack", 32'(ack), 32'h08);
        @(negedge clk);
        prio_mode = 1'b1;
        req       = 8'h28;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("fixed_ack", 32'(ack), 32'h08);
            @(negedge clk);
        end
        #1;
        check("fixed_src", 32'(out_src), 32'h3);
        prio_mode = 1'b0;
        #1;
        check("rr_resume_ack", 32'(ack), 32'h20);
        @(negedge clk); #1;
        check("rr_resume_src", 32'(out_src), 32'h5);

        // Sole requester 7 with changing data
        req  = 8'h80;
        d[7] = 8'd123;
        #1;
        check("sole_ack0", 32'(ack), 32'h80);
        @(negedge clk);
        d[7] = 8'd77;
        #1;
        check("sole_data0", 32'(out_data), 32'd123);
        check("sole_sel0",  32'(sel),      32'h80);
        check("sole_ack1",  32'(ack),      32'h80);
        @(negedge clk);
        req = 8'h00;
        #1;
        check("sole_data1", 32'(out_data), 32'd77);
        check("sole_sel1",  32'(sel),      32'h80);
        @(negedge clk);

        // Fill, stall, then reset mid-transfer
        req       = 8'h01;
        out_ready = 1'b0;
        #1;
        check("fill_ack", 32'(ack), 32'h01);
        @(negedge clk);
        req = 8'hFF;
        #1;
        check("full_stall_ack", 32'(ack),       32'h0);
        check("full_valid",     32'(out_valid), 32'h1);
        check("full_sel",       32'(sel),       32'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_ack",   32'(ack),       32'h0);
        check("arst_sel",   32'(sel),       32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_ack", 32'(ack), 32'h01);
        @(negedge clk); #1;
        check("post_rst_valid", 32'(out_valid), 32'h1);
        check("post_rst_src",   32'(out_src),   32'h0);
        check("post_rst_ack2",  32'(ack),       32'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_select_arbiter_8.md
# rr_select_arbiter_8

Round-robin arbiter that shares one N-bit 8-to-1 one-hot data selector among eight requesters. Picks one requester per transfer, drives the selector's one-hot `sel`, and captures the selected word into a one-entry output register with a valid/ready handshake. Sits between eight producer blocks and a single downstream consumer.

## Interface

Parameters:
- `DATA_WIDTH`, 8, width of every data word.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  8  request per requester; bit i held high while `d<i>` is valid.
- `d0`..`d7`  in  DATA_WIDTH each  requester data words.
- `prio_mode`  in  1  0 = round-robin, 1 = fixed priority (requester 0 highest).
- `ack`  out  8  combinational one-hot; bit i high in the cycle whose closing edge captures `d<i>`.
- `sel`  out  8  registered one-hot select of the last captured requester.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DATA_WIDTH  captured word.
- `out_src`  out  3  binary index of the captured requester.

## Operation

- State: `EMPTY` (`out_valid`=0) / `FULL` (`out_valid`=1); the state is `out_valid` itself.
- `load` = (|req) && (!out_valid || out_ready).
- Arbitration (combinational, every cycle): round-robin mode scans from `ptr` upward with wrap 7→0, and the first set `req` bit wins. Fixed mode picks the lowest set `req` bit and ignores `ptr`.
- `grant` is one-hot of the winner, all zero if `req`==0. `ack` = load ? grant : 0. `ack` is forced to 0 while `rst_n`=0.
- Data path: `grant` drives a one-hot 8:1 selector and its output feeds the output register.
- On an edge with `load`:
  - `out_data` ← selected word, `out_src` ← winner index, `sel` ← grant, `out_valid` ← 1.
  - In round-robin mode `ptr` ← (winner+1) mod 8. In fixed mode `ptr` is unchanged.
- On an edge with out_valid && out_ready && !load: `out_valid` ← 0. `out_data`, `out_src` and `sel` keep their values.
- FULL and !out_ready: every output register is frozen, `ack`=0, and `req` changes are ignored.
- Simultaneous drain and load (FULL, out_ready=1, |req): the old word transfers and the new word is captured on the same edge. No bubble.
- Requester contract: after seeing `ack[i]`=1 at an edge, the requester either drops `req[i]` or presents its next word.
- `prio_mode` may change any cycle and takes effect on the next arbitration. `ptr` is preserved across mode changes.

## Timing

- Reset values: `out_valid`=0, `out_data`=0, `out_src`=0, `sel`=8'b0, `ptr`=0, `ack`=0.
- Latency is 1 cycle: a word acked in cycle N appears on `out_data` with `out_valid`=1 in cycle N+1.
- Throughput is 1 word per cycle while out_ready=1 and |req.
- Round-robin fairness: with all eight `req` high and out_ready=1, grants go 0,1,…,7,0 on consecutive cycles. A requester waits at most 7 transfers.
- `ptr` wraps 7→0. A sole requester is re-granted every transfer.
- Reset asserted mid-transfer: all registers take their reset values immediately, any in-flight word is discarded, and `ack`=0.
- `ack` is the only combinational output. Its path is req/ptr/prio_mode/out_valid/out_ready → ack.

## Structure

- Shared package/include holds:
  - `NUM_REQ`=8 and `SRC_W`=3.
  - A one-hot-to-binary function.
  - The round-robin pick function (req, ptr → one-hot grant).
- Sub-module `onehot_mux_8`, parameterized by DATA_WIDTH, with inputs d0..d7 and one-hot sel and output y. It is purely combinational and outputs 0 for an all-zero sel. It is instantiated once and driven by `grant`.
- The top level holds the arbitration logic, `ptr`, and the output register/handshake.

## Test plan

- Reset with d0..d7=0..7, `req`=0 → out_valid=0, out_data=0, sel=0, ack=0 for 5 cycles.
- prio_mode=0, req=8'hFF, out_ready=1 → ack walks 01,02,04,…,80,01. The next cycle has out_data=0..7,0 and out_src equal to out_data.
- req=8'h81, ptr=0, out_ready=0 → ack=01 once, then out_valid=1, out_data=0, held for 4 cycles with ack=0. Raising out_ready drains it and acks requester 7 on the same edge, so out_data=7 follows.
- prio_mode=1, req=8'h28 held, out_ready=1 → every transfer grants requester 3. Switching to prio_mode=0 grants requester 5 next.
- d7=123 then d7=77 with only req[7] set → out_data shows 123 then 77 on consecutive cycles with sel=8'h80.
- Assert rst_n=0 while FULL with out_ready=0 → out_valid=0 and ack=0 immediately. After release with req=8'hFF, requester 0 is granted first.
